// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and types for the instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // ADD r0,r0,r0

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // One queued fetch: PC in the upper half, instruction word in the lower half
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO with flush. No bypass: a pushed entry
//               is visible at the head one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage array; stale contents are harmless because count gates validity
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush behaves like a reset of the queue
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Fetch stage: issues word-address requests to instruction
//               memory, buffers returned words with their PC and presents
//               them to the decoder. Redirect flushes the queue and squashes
//               any in-flight fetch.
//               Optional macro FETCH_STATS_EN adds stall/squash counters.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       instr_valid,
  output logic [31:0]                instr_out,
  output logic [31:0]                instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] queue_count
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [15:0]                squash_count
`endif
);

  localparam int                CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t     state;
  logic [31:0]      fetch_pc;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_after_pop;
  logic [CNT_W-1:0] count_after;
  logic [31:0]      redirect_aligned;
  logic             unused_redirect_lsbs;

  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A redirect squashes both the returning word and any same-cycle pop
  assign push            = (state == REQ) && imem_ack && !redirect_valid;
  assign pop             = instr_valid && instr_ready && !redirect_valid;
  assign count_after_pop = count - CNT_W'(pop);
  assign count_after     = count_after_pop + CNT_W'(push);

  assign push_entry.pc    = fetch_pc;
  assign push_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  // Fetch FSM; addr_q freezes on the squashed address while in DISCARD
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            addr_q   <= redirect_aligned;
          end else if (count_after_pop < DEPTH_C) begin
            // Slot is reserved now, so the eventual push cannot overflow
            state  <= REQ;
            addr_q <= fetch_pc;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            if (imem_ack) begin
              state  <= IDLE;
              addr_q <= redirect_aligned;
            end else begin
              state <= DISCARD;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + PC_STEP;
            addr_q   <= fetch_pc + PC_STEP;
            state    <= (count_after < DEPTH_C) ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
          end
          if (imem_ack) begin
            state  <= IDLE;
            addr_q <= redirect_valid ? redirect_aligned : fetch_pc;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (state == REQ) || (state == DISCARD);
  assign imem_addr   = addr_q;
  assign queue_count = count;
  assign instr_valid = (count != '0);
  assign instr_out   = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head.pc    : 32'h0;

`ifdef FETCH_STATS_EN
  // Saturating counters for decoder starvation/backpressure and squashes
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      squash_count <= '0;
    end else begin
      if (!(instr_valid && instr_ready) && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (redirect_valid && ((count != '0) || (state != IDLE)) &&
          (squash_count != '1)) begin
        squash_count <= squash_count + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Directed scoreboard bench for instr_fetch_queue. A second
//               instance exercises a non-zero reset PC that wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out, instr_pc;
  logic [2:0]  queue_count;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] squash_count;
  logic [31:0] stall_cycles2;
  logic [15:0] squash_count2;
`endif

  logic        imem_req2, imem_ack2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        instr_valid2;
  logic [31:0] instr_out2, instr_pc2;
  logic [2:0]  queue_count2;

  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mon_e;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .queue_count(queue_count)
`ifdef FETCH_STATS_EN
    , .stall_cycles(stall_cycles), .squash_count(squash_count)
`endif
  );

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(instr_valid2), .instr_out(instr_out2), .instr_pc(instr_pc2),
    .instr_ready(1'b1), .queue_count(queue_count2)
`ifdef FETCH_STATS_EN
    , .stall_cycles(stall_cycles2), .squash_count(squash_count2)
`endif
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances, then one idle edge so the main DUT enters REQ
  task automatic do_reset();
    reset          = 1'b1;
    imem_ack       = 1'b0;
    imem_ack2      = 1'b0;
    redirect_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Check the pending request, acknowledge it, optionally expect it at output
  task automatic issue(input string name, input logic [31:0] a, input bit expect_it);
    check32({name, "_req"}, 32'(imem_req), 32'd1);
    check32({name, "_addr"}, imem_addr, a);
    imem_ack   = 1'b1;
    imem_rdata = word_at(a);
    if (expect_it) exp_q.push_back({a, word_at(a)});
    step();
    imem_ack = 1'b0;
  endtask

  // Monitor: every consumed instruction must match the scoreboard head
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready && !redirect_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr_out);
      end else begin
        mon_e = exp_q.pop_front();
        if ({instr_pc, instr_out} !== mon_e) begin
          miscompares++;
          $display("FAIL scoreboard: got pc %h instr %h expected pc %h instr %h",
                   instr_pc, instr_out, mon_e[63:32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    imem_ack2 = 1'b0; imem_rdata2 = '0;
    step();
    step();
    check32("rst_req",   32'(imem_req),    32'd0);
    check32("rst_addr",  imem_addr,        32'h0);
    check32("rst_count", 32'(queue_count), 32'd0);
    check32("rst_valid", 32'(instr_valid), 32'd0);
    check32("rst_instr", instr_out,        32'h0);
    check32("rst_pc",    instr_pc,         32'h0);
    reset = 1'b0;
    step();

    // 1: ack every cycle, consumer always ready
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check32("t1_count", 32'(queue_count), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) check32("t1_lag_pc", instr_pc, 32'(4 * (i - 1)));
      issue("t1", 32'(4 * i), 1'b1);
    end
    step();

    // 2: fill to DEPTH with consumer stalled
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue("t2", 32'(4 * i), 1'b1);
    check32("t2_full_req",   32'(imem_req),    32'd0);
    check32("t2_full_count", 32'(queue_count), 32'd4);
    check32("t2_head_pc",    instr_pc,         32'h0);
    step();
    check32("t2_hold_req",   32'(imem_req),    32'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check32("t2_count3", 32'(queue_count), 32'd3);
    issue("t2_re", 32'h10, 1'b1);
    check32("t2_refull", 32'(queue_count), 32'd4);
    instr_ready = 1'b1;
    repeat (4) step();
    instr_ready = 1'b0;
    check32("t2_drained", 32'(queue_count), 32'd0);

    // 3: redirect without ack goes through DISCARD
    do_reset();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    check32("t3_disc_req",  32'(imem_req), 32'd1);
    check32("t3_disc_addr", imem_addr,     32'h0);
    step();
    check32("t3_hold_addr", imem_addr,     32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check32("t3_idle_req", 32'(imem_req),    32'd0);
    check32("t3_count",    32'(queue_count), 32'd0);
    step();

    // 4: redirect and ack in the same cycle with three queued
    instr_ready = 1'b0;
    issue("t4_a", 32'h100, 1'b0);
    issue("t4_b", 32'h104, 1'b0);
    issue("t4_c", 32'h108, 1'b0);
    check32("t4_count3", 32'(queue_count), 32'd3);
    check32("t4_addr",   imem_addr,        32'h10C);
    imem_ack       = 1'b1;
    imem_rdata     = 32'hBAD0_BAD0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    check32("t4_count0", 32'(queue_count), 32'd0);
    check32("t4_valid",  32'(instr_valid), 32'd0);
    check32("t4_nop",    instr_out,        32'h0);
    check32("t4_nodisc", 32'(imem_req),    32'd0);
    step();
    instr_ready = 1'b1;
    issue("t4_new", 32'h200, 1'b1);
    step();

    // 5: reset PC near the top of the address space wraps to 0
    do_reset();
    check32("t5_addr0", imem_addr2, 32'hFFFF_FFF8);
    imem_ack2   = 1'b1;
    imem_rdata2 = word_at(32'hFFFF_FFF8);
    step();
    check32("t5_addr1", imem_addr2, 32'hFFFF_FFFC);
    check32("t5_pc0",   instr_pc2,  32'hFFFF_FFF8);
    imem_rdata2 = word_at(32'hFFFF_FFFC);
    step();
    imem_ack2 = 1'b0;
    check32("t5_pc1",   instr_pc2,  32'hFFFF_FFFC);
    check32("t5_ins1",  instr_out2, word_at(32'hFFFF_FFFC));
    check32("t5_wrap",  imem_addr2, 32'h0);

`ifdef FETCH_STATS_EN
    // 6: statistics counters
    do_reset();
    instr_ready = 1'b0;
    repeat (4) step();
    check32("t6_stall", stall_cycles, 32'd5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    check32("t6_squash", 32'(squash_count), 32'd1);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    reset = 1'b1;
    step();
    check32("t6_rst_stall",  stall_cycles,        32'd0);
    check32("t6_rst_squash", 32'(squash_count),   32'd0);
    check32("t6_rst_req",    32'(imem_req),       32'd0);
    reset = 1'b0;
    step();
`endif

    repeat (3) step();
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
